// File: rtl/csr_access_ctrl_pkg.sv
// Shared types and constants for the CSR access controller: op codes, FSM states,
// machine-mode CSR addresses and the ECALL cause code.
package csr_access_ctrl_pkg;

    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    typedef enum logic [3:0] {
        OP_RW    = 4'd0,
        OP_RS    = 4'd1,
        OP_RC    = 4'd2,
        OP_RWI   = 4'd3,
        OP_RSI   = 4'd4,
        OP_RCI   = 4'd5,
        OP_ECALL = 4'd6,
        OP_MRET  = 4'd7
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TRAP,
        S_RESP
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ECALL_M = 64'd11;

    function automatic logic is_csr_op(input logic [3:0] op);
        return (op == OP_RW) || (op == OP_RS) || (op == OP_RC) ||
               (op == OP_RWI) || (op == OP_RSI) || (op == OP_RCI);
    endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// Initiator side of the CSR file port: runs Zicsr read-modify-write ops, ECALL and MRET,
// one op in flight, returning the old CSR value or a fetch redirect.
//
// state  | meaning
// S_IDLE | ready for a new op
// S_RD   | CSR read address driven, old value captured
// S_WR   | new value written (skipped for set/clear with zero source)
// S_TRAP | one-cycle ecall pulse to the CSR file
// S_RESP | result held until the consumer accepts it
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int                XLEN_P     = XLEN,
    parameter int                CSR_AW_P   = CSR_AW,
    parameter logic [CSR_AW_P-1:0] MTVEC_ADDR = CSR_MTVEC,
    parameter logic [CSR_AW_P-1:0] MEPC_ADDR  = CSR_MEPC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_op,
    input  logic [CSR_AW_P-1:0] in_csr,
    input  logic [XLEN_P-1:0]   in_src,
    input  logic [4:0]          in_zimm,
    input  logic [4:0]          in_rd,
    input  logic [XLEN_P-1:0]   in_pc,
    output logic [CSR_AW_P-1:0] csr_rnum,
    input  logic [XLEN_P-1:0]   csr_rdata,
    output logic [CSR_AW_P-1:0] csr_wnum,
    output logic                csr_wen,
    output logic [XLEN_P-1:0]   csr_wdata,
    output logic [XLEN_P-1:0]   csr_wmask,
    output logic                ecall,
    output logic [XLEN_P-1:0]   pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_rd_we,
    output logic [4:0]          out_rd,
    output logic [XLEN_P-1:0]   out_rdata,
    output logic                out_redir,
    output logic [XLEN_P-1:0]   out_target
);

    state_e              state, state_nxt;
    logic [3:0]          op_q;
    logic [CSR_AW_P-1:0] csr_q;
    logic [XLEN_P-1:0]   src_q;
    logic [4:0]          rd_q;
    logic [XLEN_P-1:0]   pc_q;
    logic [XLEN_P-1:0]   old_q;
    logic                accept;
    logic                op_is_csr;
    logic                op_is_imm;
    logic                op_writes;
    logic [XLEN_P-1:0]   new_val;

    function automatic logic [XLEN_P-1:0] csr_alu(input logic [3:0] op,
                                                  input logic [XLEN_P-1:0] old,
                                                  input logic [XLEN_P-1:0] src);
        case (op)
            OP_RS, OP_RSI: return old | src;
            OP_RC, OP_RCI: return old & ~src;
            default:       return src;
        endcase
    endfunction

    assign accept    = (state == S_IDLE) && in_valid;
    assign op_is_csr = is_csr_op(op_q);
    assign op_is_imm = (in_op == OP_RWI) || (in_op == OP_RSI) || (in_op == OP_RCI);
    // set/clear with a zero source must not touch the CSR (side-effect free read)
    assign op_writes = (op_q == OP_RW) || (op_q == OP_RWI) || (src_q != '0);
    assign new_val   = csr_alu(op_q, old_q, src_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            csr_q <= '0;
            src_q <= '0;
            rd_q  <= '0;
            pc_q  <= '0;
            old_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= in_op;
                csr_q <= in_csr;
                src_q <= op_is_imm ? {{(XLEN_P-5){1'b0}}, in_zimm} : in_src;
                rd_q  <= in_rd;
                pc_q  <= in_pc;
                old_q <= '0;
            end else if (state == S_RD) begin
                old_q <= csr_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        csr_rnum   = '0;
        csr_wnum   = '0;
        csr_wen    = 1'b0;
        csr_wdata  = '0;
        csr_wmask  = '0;
        ecall      = 1'b0;
        out_valid  = 1'b0;
        out_rd_we  = 1'b0;
        out_rd     = '0;
        out_rdata  = '0;
        out_redir  = 1'b0;
        out_target = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_csr_op(in_op) || in_op == OP_MRET) state_nxt = S_RD;
                    else if (in_op == OP_ECALL)               state_nxt = S_TRAP;
                    else                                      state_nxt = S_RESP;
                end
            end
            S_RD: begin
                if (op_q == OP_ECALL)     csr_rnum = MTVEC_ADDR;
                else if (op_q == OP_MRET) csr_rnum = MEPC_ADDR;
                else                      csr_rnum = csr_q;
                state_nxt = op_is_csr ? S_WR : S_RESP;
            end
            S_WR: begin
                csr_wnum  = csr_q;
                csr_wdata = new_val;
                csr_wen   = op_writes && !rst;
                state_nxt = S_RESP;
            end
            S_TRAP: begin
                ecall     = !rst;
                state_nxt = S_RD;
            end
            S_RESP: begin
                out_valid = 1'b1;
                out_rd    = rd_q;
                out_rdata = old_q;
                if (op_is_csr) begin
                    out_rd_we = (rd_q != 5'd0);
                end else if (op_q == OP_ECALL) begin
                    out_redir  = 1'b1;
                    out_target = {old_q[XLEN_P-1:2], 2'b00};
                end else if (op_q == OP_MRET) begin
                    out_redir  = 1'b1;
                    out_target = old_q;
                end
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR file and a result scoreboard.
module tb_csr_access_ctrl;
    import csr_access_ctrl_pkg::*;

    typedef struct {
        logic        rd_we;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        chk_rdata;
        logic        redir;
        logic [63:0] target;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [11:0] in_csr;
    logic [63:0] in_src;
    logic [4:0]  in_zimm;
    logic [4:0]  in_rd;
    logic [63:0] in_pc;
    logic [11:0] csr_rnum;
    logic [63:0] csr_rdata;
    logic [11:0] csr_wnum;
    logic        csr_wen;
    logic [63:0] csr_wdata;
    logic [63:0] csr_wmask;
    logic        ecall;
    logic [63:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic        out_rd_we;
    logic [4:0]  out_rd;
    logic [63:0] out_rdata;
    logic        out_redir;
    logic [63:0] out_target;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_mscratch = '0;
    int          wen_cnt = 0;
    int          ecall_cnt = 0;
    int          both_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [63:0] last_wmask = '0;
    logic [11:0] last_wnum = '0;
    logic [63:0] last_pc = '0;

    csr_access_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_csr(in_csr),
        .in_src(in_src), .in_zimm(in_zimm), .in_rd(in_rd), .in_pc(in_pc),
        .csr_rnum(csr_rnum), .csr_rdata(csr_rdata), .csr_wnum(csr_wnum),
        .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .ecall(ecall), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_we(out_rd_we),
        .out_rd(out_rd), .out_rdata(out_rdata), .out_redir(out_redir),
        .out_target(out_target)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, write/trap effects committed at the clock edge
    always_comb begin
        csr_rdata = '0;
        case (csr_rnum)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h340: csr_rdata = m_mscratch;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            wen_cnt    <= wen_cnt + 1;
            last_wdata <= csr_wdata;
            last_wmask <= csr_wmask;
            last_wnum  <= csr_wnum;
            if (csr_wnum == 12'h340) m_mscratch <= csr_wdata | csr_wmask;
        end
        if (ecall) begin
            ecall_cnt <= ecall_cnt + 1;
            last_pc   <= pc;
        end
        if (csr_wen && ecall) both_cnt <= both_cnt + 1;
        if (rst) begin
            m_mstatus <= 64'ha_0000_1800;
            m_mtvec   <= '0;
            m_mepc    <= '0;
            m_mcause  <= '0;
        end else begin
            if (csr_wen) begin
                case (csr_wnum)
                    12'h300: m_mstatus <= csr_wdata | csr_wmask;
                    12'h305: m_mtvec   <= csr_wdata | csr_wmask;
                    12'h341: m_mepc    <= csr_wdata | csr_wmask;
                    12'h342: m_mcause  <= csr_wdata | csr_wmask;
                    default: ;
                endcase
            end
            if (ecall) begin
                m_mepc   <= pc;
                m_mcause <= 64'd11;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [11:0] csr,
                          input logic [63:0] src, input logic [4:0] zimm, input logic [4:0] rd,
                          input logic [63:0] pcv, input exp_t e, input int exp_wen,
                          input int exp_ecall, input int hold);
        int   w0;
        int   c0;
        int   k;
        exp_t got;
        logic [133:0] snap;
        w0 = wen_cnt;
        c0 = ecall_cnt;
        k  = 0;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; in_op = op; in_csr = csr; in_src = src;
        in_zimm = zimm; in_rd = rd; in_pc = pcv;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (out_valid !== 1'b1 && k < 20);
        chk({name, "_out_valid"}, out_valid, 1'b1);
        got = sb.pop_front();
        if (got.lat != 0) chk({name, "_latency"}, k, got.lat);
        chk({name, "_rd_we"}, out_rd_we, got.rd_we);
        chk({name, "_rd"}, out_rd, got.rd);
        if (got.chk_rdata) chk({name, "_rdata"}, out_rdata, got.rdata);
        chk({name, "_redir"}, out_redir, got.redir);
        chk({name, "_target"}, out_target, got.target);
        if (hold > 0) begin
            snap = {out_rd_we, out_rd, out_rdata, out_redir, out_target};
            for (int i = 1; i <= hold; i++) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, out_valid, 1'b1);
                chk({name, "_hold_in_ready"}, in_ready, 1'b0);
                chk({name, "_hold_stable"}, {out_rd_we, out_rd, out_rdata, out_redir, out_target}, snap);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({name, "_retired"}, out_valid, 1'b0);
        chk({name, "_idle_ready"}, in_ready, 1'b1);
        chk({name, "_wen_count"}, wen_cnt - w0, exp_wen);
        chk({name, "_ecall_count"}, ecall_cnt - c0, exp_ecall);
    endtask

    function automatic exp_t mk(input logic rd_we, input logic [4:0] rd, input logic [63:0] rdata,
                                input logic chk_rdata, input logic redir,
                                input logic [63:0] target, input int lat);
        exp_t e;
        e.rd_we = rd_we; e.rd = rd; e.rdata = rdata; e.chk_rdata = chk_rdata;
        e.redir = redir; e.target = target; e.lat = lat;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_csr = '0; in_src = '0;
        in_zimm = '0; in_rd = '0; in_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_wen", csr_wen, 1'b0);
        chk("reset_ecall", ecall, 1'b0);
        chk("reset_rnum", csr_rnum, 12'h0);
        chk("reset_outs", {out_rd_we, out_rd, out_rdata, out_redir, out_target}, '0);

        run_op("rs_mstatus_zero", OP_RS, 12'h300, 64'h0, 5'd0, 5'd5, 64'h0,
               mk(1'b1, 5'd5, 64'ha_0000_1800, 1'b1, 1'b0, 64'h0, 3), 0, 0, 0);

        run_op("rw_mtvec", OP_RW, 12'h305, 64'h8000_0100, 5'd0, 5'd1, 64'h0,
               mk(1'b1, 5'd1, 64'h0, 1'b1, 1'b0, 64'h0, 3), 1, 0, 0);
        chk("rw_mtvec_wdata", last_wdata, 64'h8000_0100);
        chk("rw_mtvec_wnum", last_wnum, 12'h305);
        chk("rw_mtvec_wmask", last_wmask, 64'h0);

        run_op("rci_zero", OP_RCI, 12'h300, 64'hffff, 5'd0, 5'd0, 64'h0,
               mk(1'b0, 5'd0, 64'ha_0000_1800, 1'b1, 1'b0, 64'h0, 3), 0, 0, 0);

        run_op("rc_mstatus", OP_RC, 12'h300, 64'h1800, 5'd0, 5'd2, 64'h0,
               mk(1'b1, 5'd2, 64'ha_0000_1800, 1'b1, 1'b0, 64'h0, 3), 1, 0, 0);
        chk("rc_mstatus_wdata", last_wdata, 64'ha_0000_0000);

        run_op("rsi_unknown", OP_RSI, 12'h7c0, 64'hffff_0000, 5'h13, 5'd3, 64'h0,
               mk(1'b1, 5'd3, 64'h0, 1'b1, 1'b0, 64'h0, 3), 1, 0, 0);
        chk("rsi_unknown_wdata", last_wdata, 64'h13);
        chk("rsi_unknown_wnum", last_wnum, 12'h7c0);

        run_op("rw_mtvec2", OP_RW, 12'h305, 64'h8000_0101, 5'd0, 5'd0, 64'h0,
               mk(1'b0, 5'd0, 64'h8000_0100, 1'b1, 1'b0, 64'h0, 3), 1, 0, 0);

        run_op("ecall", OP_ECALL, 12'h0, 64'h0, 5'd0, 5'd9, 64'h8000_0010,
               mk(1'b0, 5'd9, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 3), 0, 1, 0);
        chk("ecall_pc", last_pc, 64'h8000_0010);

        run_op("mret", OP_MRET, 12'h0, 64'h0, 5'd0, 5'd8, 64'h0,
               mk(1'b0, 5'd8, 64'h0, 1'b0, 1'b1, 64'h8000_0010, 2), 0, 0, 0);

        run_op("undef_op", 4'hf, 12'h300, 64'h1, 5'd0, 5'd7, 64'h0,
               mk(1'b0, 5'd7, 64'h0, 1'b0, 1'b0, 64'h0, 0), 0, 0, 0);

        out_ready = 1'b0;
        run_op("hold", OP_RS, 12'h305, 64'h0, 5'd0, 5'd4, 64'h0,
               mk(1'b1, 5'd4, 64'h8000_0101, 1'b1, 1'b0, 64'h0, 3), 0, 0, 3);

        // reset asserted while the write is being presented
        w0 = wen_cnt;
        @(negedge clk);
        chk("rstwr_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_op = OP_RW; in_csr = 12'h340; in_src = 64'h55; in_rd = 5'd6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_pre_wen", csr_wen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_wen", csr_wen, 1'b0);
        chk("rstwr_in_ready", in_ready, 1'b1);
        chk("rstwr_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        chk("rstwr_no_write", wen_cnt - w0, 0);
        chk("rstwr_mscratch", m_mscratch, 64'h0);

        run_op("post_rst_rs", OP_RS, 12'h300, 64'h0, 5'd0, 5'd5, 64'h0,
               mk(1'b1, 5'd5, 64'ha_0000_1800, 1'b1, 1'b0, 64'h0, 3), 0, 0, 0);

        chk("wen_ecall_exclusive", both_cnt, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
